// File: rtl/font_arb_pkg.sv
// font_arb_pkg: shared defaults and types for the font ROM arbiter
// Provides the default ROM geometry (address/data width, read latency)
// and the font_addr_t address type used by font ROM clients.
package font_arb_pkg;
    localparam int FONT_ADDR_W      = 11;
    localparam int FONT_DATA_W      = 8;
    localparam int FONT_ROM_LATENCY = 1;
    typedef logic [FONT_ADDR_W-1:0] font_addr_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant with registered rotating pointer
// Ports:
//   clk   - clock
//   rst   - asynchronous active-low reset (pointer to 0, grant forced low)
//   req   - per-requester request
//   gnt   - combinational one-hot grant, searched from the pointer upward
module rr_arbiter
    import font_arb_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt
);
    localparam int PW = $clog2(N_REQ);

    logic [PW-1:0]    ptr_q, ptr_d;
    logic [N_REQ-1:0] gnt_d;

    // Offsets are scanned farthest-first so the nearest requesting index
    // (offset 0 = ptr) overwrites any earlier candidate.
    always_comb begin
        int idx;
        idx   = 0;
        gnt_d = '0;
        ptr_d = ptr_q;
        for (int o = N_REQ - 1; o >= 0; o--) begin
            idx = int'(ptr_q) + o;
            idx = (idx >= N_REQ) ? idx - N_REQ : idx;
            for (int i = 0; i < N_REQ; i++) begin
                if (i == idx && req[i]) begin
                    gnt_d    = '0;
                    gnt_d[i] = 1'b1;
                    ptr_d    = (i == N_REQ - 1) ? '0 : PW'(i + 1);
                end
            end
        end
    end

    assign gnt = rst ? gnt_d : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ptr_q <= '0;
        else      ptr_q <= ptr_d;
    end
endmodule

// File: rtl/font_rom_arbiter.sv
// font_rom_arbiter: round-robin sharing of one synchronous font ROM between requesters
// Ports:
//   clk      - pixel clock
//   rst      - asynchronous active-low reset
//   req      - per-requester read request, held until granted
//   addr     - per-requester ROM address
//   gnt      - combinational one-hot grant
//   rom_addr - registered address to the ROM
//   rom_data - ROM read data
//   rdata    - returned data (rom_data passed through)
//   rvalid   - one-hot owner of rdata this cycle
module font_rom_arbiter
    import font_arb_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int ADDR_W      = FONT_ADDR_W,
    parameter int DATA_W      = FONT_DATA_W,
    parameter int ROM_LATENCY = FONT_ROM_LATENCY
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             req,
    input  logic [N_REQ-1:0][ADDR_W-1:0] addr,
    output logic [N_REQ-1:0]             gnt,
    output logic [ADDR_W-1:0]            rom_addr,
    input  logic [DATA_W-1:0]            rom_data,
    output logic [DATA_W-1:0]            rdata,
    output logic [N_REQ-1:0]             rvalid
);
    // One stage for the address register plus one per ROM latency cycle.
    localparam int DEPTH = ROM_LATENCY + 1;

    logic [ADDR_W-1:0]            rom_addr_q, rom_addr_d, sel_addr;
    logic [DEPTH-1:0][N_REQ-1:0]  tag_q, tag_d;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .clk (clk),
        .rst (rst),
        .req (req),
        .gnt (gnt)
    );

    // gnt is one-hot, so an AND-OR mux selects the granted address.
    always_comb begin
        sel_addr = '0;
        for (int i = 0; i < N_REQ; i++) sel_addr |= addr[i] & {ADDR_W{gnt[i]}};
    end

    assign rom_addr_d = |gnt ? sel_addr : rom_addr_q;
    assign tag_d      = {tag_q[DEPTH-2:0], gnt};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rom_addr_q <= '0;
            tag_q      <= '0;
        end else begin
            rom_addr_q <= rom_addr_d;
            tag_q      <= tag_d;
        end
    end

    assign rom_addr = rom_addr_q;
    assign rvalid   = tag_q[DEPTH-1];
    assign rdata    = rom_data;
endmodule

// File: tb/tb_font_rom_arbiter.sv
// tb_font_rom_arbiter: directed self-checking bench for font_rom_arbiter
module tb_font_rom_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic [1:0]       req2, gnt2, rvalid2;
    logic [1:0][10:0] addr2;
    logic [10:0]      rom_addr2;
    logic [7:0]       rom_data2, rdata2;

    logic [2:0]       req3, gnt3, rvalid3;
    logic [2:0][10:0] addr3;
    logic [10:0]      rom_addr3;
    logic [7:0]       rom_data3, rdata3;

    logic [1:0]       reql, gntl, rvalidl;
    logic [1:0][10:0] addrl;
    logic [10:0]      rom_addrl, al1, al2;
    logic [7:0]       rom_datal, rdatal;

    always #5 clk = ~clk;

    font_rom_arbiter #(.N_REQ(2)) u2 (
        .clk(clk), .rst(rst), .req(req2), .addr(addr2), .gnt(gnt2),
        .rom_addr(rom_addr2), .rom_data(rom_data2), .rdata(rdata2), .rvalid(rvalid2)
    );
    font_rom_arbiter #(.N_REQ(3)) u3 (
        .clk(clk), .rst(rst), .req(req3), .addr(addr3), .gnt(gnt3),
        .rom_addr(rom_addr3), .rom_data(rom_data3), .rdata(rdata3), .rvalid(rvalid3)
    );
    font_rom_arbiter #(.N_REQ(2), .ROM_LATENCY(3)) ul (
        .clk(clk), .rst(rst), .req(reql), .addr(addrl), .gnt(gntl),
        .rom_addr(rom_addrl), .rom_data(rom_datal), .rdata(rdatal), .rvalid(rvalidl)
    );

    function automatic logic [7:0] rom_f(input logic [10:0] a);
        return a[7:0] ^ {a[10:8], a[10:8], a[9:8]};
    endfunction

    always @(posedge clk) begin
        rom_data2 <= rom_f(rom_addr2);
        rom_data3 <= rom_f(rom_addr3);
        al1       <= rom_addrl;
        al2       <= al1;
        rom_datal <= rom_f(al2);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0]  e2;
        logic [2:0]  e3;
        logic [10:0] ea;
        rst = 1'b0;
        req2 = '0; req3 = '0; reql = '0;
        addr2 = '0; addr3 = '0; addrl = '0;
        addr2[0] = 11'h412;
        addr2[1] = 11'h7A5;
        req2 = 2'b11;
        #2;
        chk("rst_gnt", 32'(gnt2), 32'h0);
        chk("rst_rvalid", 32'(rvalid2), 32'h0);
        chk("rst_rom_addr", 32'(rom_addr2), 32'h0);
        tick();
        tick();
        rst = 1'b1;
        for (int c = 0; c < 8; c++) begin
            req2 = (c < 4) ? 2'b11 : 2'b00;
            #1;
            e2 = (c % 2 == 1) ? 2'b10 : 2'b01;
            chk($sformatf("cont_gnt c%0d", c), 32'(gnt2), (c < 4) ? 32'(e2) : 32'h0);
            chk($sformatf("cont_rvalid c%0d", c), 32'(rvalid2), (c >= 2 && c < 6) ? 32'(e2) : 32'h0);
            if (c >= 2 && c < 6)
                chk($sformatf("cont_rdata c%0d", c), 32'(rdata2), 32'(rom_f(e2[1] ? 11'h7A5 : 11'h412)));
            ea = (c == 0) ? 11'h000 : (c >= 4 || (c - 1) % 2 == 1) ? 11'h7A5 : 11'h412;
            chk($sformatf("cont_rom_addr c%0d", c), 32'(rom_addr2), 32'(ea));
            tick();
        end
        for (int c = 0; c < 8; c++) begin
            req2 = (c < 5) ? 2'b01 : 2'b00;
            addr2[0] = 11'(c);
            #1;
            chk($sformatf("single_gnt c%0d", c), 32'(gnt2), (c < 5) ? 32'h1 : 32'h0);
            chk($sformatf("single_rvalid c%0d", c), 32'(rvalid2), (c >= 2 && c <= 6) ? 32'h1 : 32'h0);
            if (c >= 2 && c <= 6)
                chk($sformatf("single_rdata c%0d", c), 32'(rdata2), 32'(rom_f(11'(c - 2))));
            ea = (c == 0) ? 11'h7A5 : (c <= 5) ? 11'(c - 1) : 11'h004;
            chk($sformatf("single_rom_addr c%0d", c), 32'(rom_addr2), 32'(ea));
            tick();
        end
        addr2[0] = 11'h412;
        req2 = 2'b10; #1; chk("fair_alone1", 32'(gnt2), 32'h2); tick();
        req2 = 2'b11; #1; chk("fair_next0", 32'(gnt2), 32'h1); tick();
        req2 = 2'b11; #1; chk("fair_then1", 32'(gnt2), 32'h2); tick();
        req2 = 2'b00;
        repeat (3) tick();
        req2 = 2'b10; #1; chk("mid_g1", 32'(gnt2), 32'h2); tick();
        req2 = 2'b01; #1; chk("mid_g0", 32'(gnt2), 32'h1); tick();
        req2 = 2'b00; #1;
        chk("mid_pre_rvalid", 32'(rvalid2), 32'h2);
        #1 rst = 1'b0;
        #1;
        chk("mid_rst_rvalid", 32'(rvalid2), 32'h0);
        chk("mid_rst_rom_addr", 32'(rom_addr2), 32'h0);
        tick();
        tick();
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("post_rst_rvalid c%0d", c), 32'(rvalid2), 32'h0);
            tick();
        end
        req2 = 2'b11; #1; chk("post_rst_ptr", 32'(gnt2), 32'h1); tick();
        req2 = 2'b00;
        addr3[0] = 11'h011;
        addr3[1] = 11'h122;
        addr3[2] = 11'h233;
        for (int c = 0; c < 6; c++) begin
            req3 = 3'b111;
            #1;
            e3 = 3'b001 << (c % 3);
            chk($sformatf("n3_gnt c%0d", c), 32'(gnt3), 32'(e3));
            e3 = 3'b001 << ((c + 1) % 3);
            chk($sformatf("n3_rvalid c%0d", c), 32'(rvalid3), (c >= 2) ? 32'(e3) : 32'h0);
            tick();
        end
        req3 = 3'b010; #1; chk("n3_only1", 32'(gnt3), 32'h2); tick();
        req3 = 3'b101; #1; chk("n3_ptr2", 32'(gnt3), 32'h4); tick();
        req3 = 3'b101; #1; chk("n3_wrap0", 32'(gnt3), 32'h1); tick();
        req3 = 3'b000;
        tick();
        addrl[0] = 11'h123;
        reql = 2'b01; #1; chk("lat3_gnt", 32'(gntl), 32'h1); tick();
        reql = 2'b00;
        for (int k = 1; k <= 5; k++) begin
            #1;
            chk($sformatf("lat3_rvalid t+%0d", k), 32'(rvalidl), (k == 4) ? 32'h1 : 32'h0);
            if (k == 4) chk("lat3_rdata", 32'(rdatal), 32'(rom_f(11'h123)));
            chk($sformatf("lat3_rom_addr t+%0d", k), 32'(rom_addrl), 32'h123);
            tick();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/font_rom_arbiter.md
# font_rom_arbiter

Round-robin scheduler that shares the single synchronous `font_rom` between several text-overlay requesters (e.g. two `draw_rect_char` instances) in the 40 MHz VGA pipeline. It accepts per-requester address requests, issues one ROM read per cycle, tracks in-flight reads through the ROM latency, and returns the pixel byte tagged with a one-hot valid to the requester that issued it.

## Interface
- `N_REQ`, 2: number of requesters (2..8).
- `ADDR_W`, 11: ROM address width, `{char_code[6:0], char_line[3:0]}`.
- `DATA_W`, 8: ROM data width (one character line).
- `ROM_LATENCY`, 1: cycles from `rom_addr` change to valid `rom_data` (1..4).

Ports:
- `clk`, input, 1: pixel clock. The block uses a single clock.
- `rst`, input, 1: reset, asynchronous and active-low.
- `req`, input, N_REQ: per-requester read request. Held until granted.
- `addr`, input, N_REQ x ADDR_W: per-requester address, stable while `req` is high.
- `gnt`, output, N_REQ: one-hot grant, combinational, in the same cycle as the accepted `req`.
- `rom_addr`, output, ADDR_W: registered address to `font_rom`.
- `rom_data`, input, DATA_W: `font_rom` read data.
- `rdata`, output, DATA_W: returned data, which is `rom_data` passed through.
- `rvalid`, output, N_REQ: one-hot, marks which requester owns `rdata` this cycle.

## Operation
- **Grant.** Round-robin over `req`. The search starts at `ptr`, the index after the last granted requester, wrapping N_REQ-1 -> 0. At most one `gnt` bit is high per cycle. With `req` all 0, `gnt` is 0.
- **Pointer update.** When any grant is issued, `ptr` <= (granted index + 1) mod N_REQ. With no grant, `ptr` holds. If a single requester is active, it is granted every cycle and gets full throughput.
- **Address register.** `rom_addr` <= `addr[g]` on a grant. With no grant, `rom_addr` holds its previous value; the ROM keeps reading, but no `rvalid` is raised.
- **Tag pipeline.** The pipeline is ROM_LATENCY+1 stages deep. Stage 0 <= `gnt` (one-hot); stage k <= stage k-1. `rvalid` is the last stage.
- **No backpressure on return.** Requesters must accept `rdata` in the cycle `rvalid` is high.
- **Simultaneous events.** A new grant and a return in the same cycle are independent. The pipeline holds up to ROM_LATENCY+1 reads in flight. Because at most one grant is issued per cycle, returns arrive in grant order.
- **Protocol rules.**
  - A requester drops `req` or changes `addr` only after the cycle its `gnt` was high.
  - `req` with no grant must be held.
  - The arbiter does not check addresses.

## Timing
- Reset (asynchronous, rst=0) sets:
  - `ptr` = 0, so requester 0 has priority first;
  - `rom_addr` = 0;
  - all tag stages = 0, so `rvalid` = 0 immediately;
  - `gnt` follows `req` combinationally and is forced to 0 while `rst` = 0.
- Reset during operation: in-flight reads are discarded and no `rvalid` appears for them after release.
- Latency, with grant in cycle t:
  - `rom_addr` updates at the edge ending t;
  - `rvalid` and matching `rdata` appear in cycle t+1+ROM_LATENCY, i.e. t+2 for the default.
- Throughput: one read per cycle in aggregate. With N contending requesters, each is served once every N cycles. Worst-case wait from `req` to `gnt` is N_REQ-1 cycles.
- Width rules: `ptr` is $clog2(N_REQ) bits, and the wrap is explicit for non-power-of-two N_REQ.

## Structure
- Package `font_arb_pkg`: defaults FONT_ADDR_W=11, FONT_DATA_W=8, FONT_ROM_LATENCY=1, and the typedef `font_addr_t` (logic [FONT_ADDR_W-1:0]).
- Sub-module `rr_arbiter`, parameterised by N_REQ: combinational one-hot grant from `req` and `ptr`, plus the registered `ptr` update. Reused for later shared ROMs such as `image_rom`.
- The top level holds the `rom_addr` register, the tag shift register and the `rdata` pass-through.
- Integration: `font_rom` is instantiated outside this block.

## Test plan
1. **Reset.** Assert rst=0 mid-stream with 2 reads in flight -> `rvalid`=0 at once, `rom_addr`=0, and no `rvalid` in the 4 cycles after release.
2. **Single requester.** `req`=01 for 5 cycles with addr 0x000..0x004 -> `gnt`[0] high every cycle; `rvalid`=01 from t+2 for 5 consecutive cycles, carrying ROM bytes for 0x000..0x004 in order.
3. **Contention after reset.** `req`=11 held -> `gnt` alternates 01,10,01,10; `rvalid` follows the same pattern 2 cycles later with the data matching each requester's addr (0x412 for req 0, 0x7A5 for req 1).
4. **Fairness after one-sided use.** Requester 1 is granted alone, then `req`=11 -> the next grant goes to requester 0.
5. **N_REQ=3 wrap.** `req`=111 -> grants 001,010,100,001; maximum wait is 2 cycles.
6. **ROM_LATENCY=3.** A single grant at t -> `rvalid` exactly at t+4; none at t+3 or t+5; `rom_addr` is unchanged while idle.
